// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: run/step/breakpoint controller for the EDiC board top.
// Turns buttons and switches into one datapath clock-enable, with debounced
// stepping, free run, sticky breakpoint hit flags and an enabled-cycle counter.
module debug_run_ctrl #(
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_BREAKPOINTS = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_btnStep,
  input  logic                                  i_swStepNRun,
  input  logic                                  i_swInstrNCycle,
  input  logic                                  i_swEnableBreakpoint,
  input  logic                                  i_instrBoundary,
  input  logic [ADDR_WIDTH-1:0]                 i_pc,
  input  logic [NUM_BREAKPOINTS*ADDR_WIDTH-1:0] i_bpAddresses,
  input  logic [NUM_BREAKPOINTS-1:0]            i_bpValid,
  output logic                                  o_cpuEnable,
  output logic                                  o_halted,
  output logic [NUM_BREAKPOINTS-1:0]            o_bpHit,
  output logic [31:0]                           o_cycleCount
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HALT,
    S_STEP_CYCLE,
    S_STEP_INSTR,
    S_RUN,
    S_BREAK
  } state_t;

  // Bit order of the synchronised switch/button bundle.
  localparam int B_BTN   = 0;
  localparam int B_STEP  = 1;
  localparam int B_INSTR = 2;
  localparam int B_BPEN  = 3;

  logic [3:0]                 sync_meta;
  logic [3:0]                 sync_q;
  logic                       step_n_run;
  logic                       instr_n_cycle;
  logic                       bp_enable;

  logic [CNT_W-1:0]           db_count;
  logic                       db_level;
  logic                       step_pulse;

  logic [NUM_BREAKPOINTS-1:0] bp_match;
  logic                       bp_fire;
  state_t                     state;
  state_t                     next_state;

  assign step_n_run    = sync_q[B_STEP];
  assign instr_n_cycle = sync_q[B_INSTR];
  assign bp_enable     = sync_q[B_BPEN];

  // Two-flop synchroniser for every input that is asynchronous to i_clk.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {i_swEnableBreakpoint, i_swInstrNCycle, i_swStepNRun, i_btnStep};
      sync_q    <= sync_meta;
    end
  end

  // Debounce: accept a new button level only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive cycles; any bounce back
  // restarts the count. A newly accepted high level emits a one-cycle step pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      db_count   <= '0;
      db_level   <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (sync_q[B_BTN] == db_level) begin
        db_count <= '0;
      end else if (db_count == CNT_LAST) begin
        db_count   <= '0;
        db_level   <= sync_q[B_BTN];
        step_pulse <= sync_q[B_BTN];
      end else begin
        db_count <= db_count + 1'b1;
      end
    end
  end

  // Breakpoint comparators: which enabled breakpoints match the current PC.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    bp_match = '0;
    for (int k = 0; k < NUM_BREAKPOINTS; k++) begin
      bp_match[k] = i_bpValid[k] && (i_bpAddresses[k*ADDR_WIDTH +: ADDR_WIDTH] == i_pc);
    end
    bp_fire = i_instrBoundary && bp_enable && (|bp_match);
  end

  // Next-state decision; a breakpoint hit outranks a switch to step mode.
  always_comb begin
    next_state = state;
    case (state)
      S_HALT: begin
        if (!step_n_run)     next_state = S_RUN;
        else if (step_pulse) next_state = instr_n_cycle ? S_STEP_INSTR : S_STEP_CYCLE;
      end
      S_STEP_CYCLE: next_state = S_HALT;
      S_STEP_INSTR: if (i_instrBoundary) next_state = S_HALT;
      S_RUN: begin
        if (bp_fire)         next_state = S_BREAK;
        else if (step_n_run) next_state = S_HALT;
      end
      S_BREAK: begin
        if (step_pulse) begin
          if (!step_n_run) next_state = S_RUN;
          else             next_state = instr_n_cycle ? S_STEP_INSTR : S_STEP_CYCLE;
        end else if (step_n_run) begin
          next_state = S_HALT;
        end
      end
      default: next_state = S_HALT;
    endcase
  end

  // FSM state with outputs registered alongside it, so they never glitch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_HALT;
      o_cpuEnable <= 1'b0;
      o_halted    <= 1'b1;
      o_bpHit     <= '0;
    end else begin
      state       <= next_state;
      o_cpuEnable <= (next_state == S_STEP_CYCLE) || (next_state == S_STEP_INSTR) ||
                     (next_state == S_RUN);
      o_halted    <= (next_state == S_HALT) || (next_state == S_BREAK);
      if (state == S_RUN && next_state == S_BREAK) begin
        o_bpHit <= bp_match;
      end else if (state == S_BREAK && next_state != S_BREAK) begin
        o_bpHit <= '0;
      end
    end
  end

  // Count every cycle in which the datapath was enabled; wraps naturally.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_cycleCount <= '0;
    end else if (o_cpuEnable) begin
      o_cycleCount <= o_cycleCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed testbench for debug_run_ctrl with a short debounce window.
module tb_debug_run_ctrl;

  localparam int AW = 16;
  localparam int NB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           btn;
  logic           sw_step;
  logic           sw_instr;
  logic           sw_bp;
  logic           boundary;
  logic [AW-1:0]  pc;
  logic [NB*AW-1:0] bp_addr;
  logic [NB-1:0]  bp_valid;
  logic           cpu_en;
  logic           halted;
  logic [NB-1:0]  bp_hit;
  logic [31:0]    cyc;

  int tests_run = 0;
  int tests_failed = 0;

  debug_run_ctrl #(
    .ADDR_WIDTH(AW),
    .NUM_BREAKPOINTS(NB),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_btnStep(btn),
    .i_swStepNRun(sw_step),
    .i_swInstrNCycle(sw_instr),
    .i_swEnableBreakpoint(sw_bp),
    .i_instrBoundary(boundary),
    .i_pc(pc),
    .i_bpAddresses(bp_addr),
    .i_bpValid(bp_valid),
    .o_cpuEnable(cpu_en),
    .o_halted(halted),
    .o_bpHit(bp_hit),
    .o_cycleCount(cyc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_enable(input string tag, input int max);
    int n;
    n = 0;
    while (!cpu_en && n < max) begin
      tick();
      n++;
    end
    check(tag, {31'd0, cpu_en}, 32'd1);
  endtask

  // Reset with step mode selected, then let the synchronisers settle (the
  // synchronisers restart at 0 = run mode, so a brief run follows release).
  task automatic reset_dut();
    rst = 1'b1; btn = 1'b0; sw_step = 1'b1; sw_instr = 1'b0; sw_bp = 1'b0;
    boundary = 1'b0; pc = '0; bp_addr = '0; bp_valid = '0;
    ticks(2);
    rst = 1'b0;
    ticks(6);
  endtask

  int c0;
  int n_en;
  int run_len;
  int max_run;

  initial begin
    rst = 1'b1; btn = 1'b0; sw_step = 1'b1; sw_instr = 1'b0; sw_bp = 1'b0;
    boundary = 1'b0; pc = '0; bp_addr = '0; bp_valid = '0;

    // ---- reset state and free run ----
    ticks(10);
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_enable", {31'd0, cpu_en}, 32'd0);
    check("rst_count", cyc, 32'd0);
    check("rst_bphit", {28'd0, bp_hit}, 32'd0);
    rst = 1'b0;
    ticks(6);
    c0 = cyc;
    ticks(10);
    check("idle_halted", {31'd0, halted}, 32'd1);
    check("idle_count", cyc, c0);
    sw_step = 1'b0;
    ticks(3);
    check("run_enable", {31'd0, cpu_en}, 32'd1);
    check("run_halted", {31'd0, halted}, 32'd0);
    c0 = cyc;
    ticks(5);
    check("run_count", cyc, c0 + 5);
    sw_step = 1'b1;
    ticks(3);
    check("stop_enable", {31'd0, cpu_en}, 32'd0);
    check("stop_halted", {31'd0, halted}, 32'd1);

    // ---- bouncing button, cycle step ----
    reset_dut();
    c0 = cyc;
    n_en = 0; run_len = 0; max_run = 0;
    for (int i = 0; i < 52; i++) begin
      if (i < 20)      btn = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
      else if (i < 40) btn = 1'b1;
      else             btn = 1'b0;
      tick();
      if (cpu_en) begin
        n_en++; run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
    check("bounce_pulses", n_en, 1);
    check("bounce_width", max_run, 1);
    check("bounce_count", cyc, c0 + 1);

    // ---- instruction step, boundary on 3rd enabled cycle ----
    reset_dut();
    sw_instr = 1'b1;
    c0 = cyc;
    btn = 1'b1;
    wait_enable("istep_start", 20);
    tick();
    check("istep_en2", {31'd0, cpu_en}, 32'd1);
    tick();
    check("istep_en3", {31'd0, cpu_en}, 32'd1);
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    check("istep_done_en", {31'd0, cpu_en}, 32'd0);
    check("istep_done_halt", {31'd0, halted}, 32'd1);
    check("istep_count", cyc, c0 + 3);
    btn = 1'b0;
    ticks(10);
    check("istep_stays", {31'd0, cpu_en}, 32'd0);

    // ---- breakpoints ----
    reset_dut();
    bp_addr[0*AW +: AW] = 16'h0028;   // matches but not valid
    bp_addr[1*AW +: AW] = 16'h0028;
    bp_addr[2*AW +: AW] = 16'h0030;
    bp_addr[3*AW +: AW] = 16'h0028;   // matches but not valid
    bp_valid = 4'b0110;
    sw_bp = 1'b1;
    sw_step = 1'b0;
    wait_enable("bp_run_start", 10);
    pc = 16'h0010; boundary = 1'b1;
    tick();
    check("bp_nomatch_en", {31'd0, cpu_en}, 32'd1);
    pc = 16'h0028; boundary = 1'b0;
    tick();
    check("bp_noboundary_en", {31'd0, cpu_en}, 32'd1);
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    check("bp_hit1_en", {31'd0, cpu_en}, 32'd0);
    check("bp_hit1_halt", {31'd0, halted}, 32'd1);
    check("bp_hit1_flags", {28'd0, bp_hit}, 32'h2);
    sw_bp = 1'b0;
    ticks(5);
    check("bp_disarm_halt", {31'd0, halted}, 32'd1);
    check("bp_disarm_flags", {28'd0, bp_hit}, 32'h2);
    sw_bp = 1'b1;
    ticks(3);
    btn = 1'b1;
    wait_enable("bp_resume1", 20);
    check("bp_resume1_flags", {28'd0, bp_hit}, 32'h0);
    btn = 1'b0;
    bp_addr[2*AW +: AW] = 16'h0028;
    ticks(8);
    check("bp_running", {31'd0, cpu_en}, 32'd1);
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    check("bp_hit2_en", {31'd0, cpu_en}, 32'd0);
    check("bp_hit2_flags", {28'd0, bp_hit}, 32'h6);
    btn = 1'b1;
    wait_enable("bp_resume2", 20);
    btn = 1'b0;
    ticks(8);
    // Switch to step mode reaches the FSM in the same cycle as a hit.
    sw_step = 1'b1;
    ticks(2);
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    check("bp_prio_flags", {28'd0, bp_hit}, 32'h6);
    check("bp_prio_halt", {31'd0, halted}, 32'd1);
    tick();
    check("bp_tohalt_flags", {28'd0, bp_hit}, 32'h0);
    check("bp_tohalt_halt", {31'd0, halted}, 32'd1);

    // ---- reset mid-STEP_INSTR ----
    reset_dut();
    sw_instr = 1'b1;
    btn = 1'b1;
    wait_enable("rmid_start", 20);
    tick();
    #2;
    rst = 1'b1;
    btn = 1'b0;
    #1;
    check("rmid_en", {31'd0, cpu_en}, 32'd0);
    check("rmid_halt", {31'd0, halted}, 32'd1);
    check("rmid_count", cyc, 32'd0);
    ticks(2);
    rst = 1'b0;
    ticks(4);
    n_en = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (cpu_en) n_en++;
    end
    check("rmid_no_step", n_en, 0);

    // ---- reset mid-debounce ----
    btn = 1'b1;
    ticks(4);
    #2;
    rst = 1'b1;
    btn = 1'b0;
    #1;
    check("rdb_en", {31'd0, cpu_en}, 32'd0);
    check("rdb_count", cyc, 32'd0);
    ticks(2);
    rst = 1'b0;
    ticks(4);
    n_en = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (cpu_en) n_en++;
    end
    check("rdb_no_step", n_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/debug_run_ctrl.md
# debug_run_ctrl

Parametrised run/step/breakpoint controller for the EDiC board top. It sits between the board buttons and switches and the datapath, and produces a single clock-enable for the CPU. It supports:
- debounced single-cycle and single-instruction stepping;
- free run;
- up to NUM_BREAKPOINTS programmable breakpoints with sticky hit flags;
- an enabled-cycle counter for the seven-segment display.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of PC and breakpoint addresses
- NUM_BREAKPOINTS, 4, number of breakpoint comparators (1..16)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a step-button change (10 ms at 5 MHz)

Ports:
- i_clk  in  1  system clock (5 MHz oscillator clock)
- i_reset  in  1  asynchronous, active-high reset
- i_btnStep  in  1  raw step button, 1 = pressed; asynchronous to i_clk
- i_swStepNRun  in  1  1 = step mode, 0 = run mode; asynchronous
- i_swInstrNCycle  in  1  1 = step one instruction, 0 = step one cycle; asynchronous
- i_swEnableBreakpoint  in  1  1 = breakpoints armed; asynchronous
- i_instrBoundary  in  1  from control unit; high in the last cycle of an instruction
- i_pc  in  ADDR_WIDTH  address of the next instruction, valid when i_instrBoundary = 1
- i_bpAddresses  in  NUM_BREAKPOINTS*ADDR_WIDTH  breakpoint k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_bpValid  in  NUM_BREAKPOINTS  per-breakpoint enable
- o_cpuEnable  out  1  datapath clock-enable, registered
- o_halted  out  1  1 in HALT or BREAK
- o_bpHit  out  NUM_BREAKPOINTS  sticky flags of the breakpoints that caused the current BREAK
- o_cycleCount  out  32  number of cycles with o_cpuEnable = 1

## Operation
- All four asynchronous inputs pass through a 2-flop synchroniser.
- Step button debounce:
  - After synchronisation, a counter restarts whenever the synchronised input differs from the debounced level.
  - The debounced level takes the new value once the input has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - A rising edge of the debounced level produces stepPulse, exactly one cycle wide.
- FSM states: HALT, STEP_CYCLE, STEP_INSTR, RUN, BREAK.
- HALT:
  - swStepNRun = 0 → RUN.
  - stepPulse with swStepNRun = 1 → STEP_CYCLE when swInstrNCycle = 0, STEP_INSTR when it is 1.
- STEP_CYCLE: lasts one cycle, then HALT.
- STEP_INSTR:
  - Stays until a cycle with i_instrBoundary = 1; that cycle is inclusive, then HALT.
  - Switch changes and stepPulse are ignored until it completes.
  - Breakpoints are not checked.
- RUN:
  - A cycle with i_instrBoundary = 1, swEnableBreakpoint = 1 and any k with i_bpValid[k] = 1 and i_bpAddresses[k] == i_pc → BREAK.
  - On that hit, o_bpHit gets the OR of all matching k.
  - Otherwise swStepNRun = 1 → HALT. This may stop mid-instruction at cycle granularity.
  - stepPulse is ignored.
  - A breakpoint hit takes priority over the switch change in the same cycle.
- BREAK:
  - stepPulse with swStepNRun = 0 → RUN. o_bpHit clears.
  - stepPulse with swStepNRun = 1 → STEP_INSTR or STEP_CYCLE as in HALT. o_bpHit clears.
  - No stepPulse, swStepNRun = 1 → HALT. o_bpHit clears.
  - Disarming breakpoints does not leave BREAK.
- Outputs are decoded from the state register:
  - o_cpuEnable = 1 in STEP_CYCLE, STEP_INSTR and RUN.
  - o_halted = 1 in HALT and BREAK.
- o_cycleCount increments in every cycle with o_cpuEnable = 1 and wraps from 0xFFFFFFFF to 0.
- Reset values: state HALT, o_cpuEnable 0, o_halted 1, o_bpHit 0, o_cycleCount 0, debounced level 0, synchronisers 0.
- Reset is asynchronous. Asserting it in any state, including mid-STEP_INSTR or mid-debounce, immediately forces all of the above.

## Timing
- Switch to state: a switch change reaches the FSM after 2 cycles of synchronisation. The state changes on the following edge.
- Button to stepPulse: the raw press must be stable for DEBOUNCE_CYCLES cycles after synchronisation. stepPulse is then high for 1 cycle.
- stepPulse in cycle t → o_cpuEnable high from cycle t+1.
- STEP_CYCLE: exactly 1 enabled cycle.
- Breakpoint hit evaluated in cycle t (o_cpuEnable = 1 in t) → o_cpuEnable = 0 and o_bpHit valid from t+1. The datapath therefore halts with PC = matched address, before executing that instruction.
- STEP_INSTR entered at t, first boundary at t+n → enabled for cycles t..t+n, HALT at t+n+1.
- Resume from BREAK into RUN: the breakpoint is checked again from the first enabled cycle. A self-jump to the same address re-hits at its next boundary.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and ADDR_WIDTH = 16.
- Reset, then hold all inputs low for 10 cycles → o_halted 1, o_cpuEnable 0, o_cycleCount 0. Setting swStepNRun = 0 → RUN, o_cpuEnable 1 by cycle 4, o_cycleCount counts up by 1 per cycle.
- Bounce: step mode, cycle step, i_btnStep toggled every 2 cycles for 20 cycles, then held 1 → exactly one enable pulse of width 1; o_cycleCount = 1.
- Instruction step: swInstrNCycle = 1, stepPulse, i_instrBoundary high on the 3rd enabled cycle → exactly 3 enabled cycles, then HALT.
- Breakpoint: i_bpAddresses[1] = 0x0028, i_bpValid = 4'b0110, armed, run, i_pc = 0x0028 with boundary → o_cpuEnable 0 next cycle, o_bpHit = 4'b0010. Second match with bp2 = 0x0028 as well → o_bpHit = 4'b0110.
- BREAK exit: stepPulse in run mode → RUN, o_bpHit 0. Same i_pc and boundary again → BREAK again.
- Reset asserted mid-STEP_INSTR and mid-debounce → outputs at reset values in the same cycle, no stepPulse after release.
